// File: rtl/spi_pred_pkg.sv
// ---------------------------------------------------------------------------
// spi_pred_pkg
//
// Shared definitions for the branch-predictor SPI transmit path.
//
// The frame layout is the contract with the off-chip host, so it lives here
// rather than inside the transmitter. Anything that builds or decodes a
// prediction frame should take its bit positions from this package.
//
//   Frame (MSB first on the wire):
//     FRESH_BIT  : holding register has not been reported yet
//     OVR_BIT    : an unread prediction was overwritten
//     TAKEN_BIT  : predicted direction (1 = taken)
//     [SUM_WIDTH-1:0] : two's-complement perceptron sum
// ---------------------------------------------------------------------------
package spi_pred_pkg;

    // Width of the perceptron sum carried in each frame.
    localparam int SUM_WIDTH  = 13;

    // Total bits shifted per frame: fresh + overrun + taken + sum.
    localparam int FRAME_BITS = SUM_WIDTH + 3;

    // Bit positions of the status fields inside a frame.
    localparam int FRESH_BIT  = FRAME_BITS - 1;
    localparam int OVR_BIT    = FRAME_BITS - 2;
    localparam int TAKEN_BIT  = FRAME_BITS - 3;

    // The bit counter has to hold the value FRAME_BITS itself.
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    // Transmit state machine.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/spi_pred_tx_sync.sv
// ---------------------------------------------------------------------------
// sync_edge_det
//
// Multi-flop synchroniser for one asynchronous input, followed by an edge
// detector. The reset value lets an idle-high signal (chip-select) and an
// idle-low signal (serial clock) both come out of reset without producing
// a spurious edge.
//
// Ports:
//   clk     : system clock
//   rst     : asynchronous, active-high reset
//   din_i   : asynchronous input
//   level_o : synchronised level
//   rise_o  : one-cycle pulse on a synchronised 0->1 transition
//   fall_o  : one-cycle pulse on a synchronised 1->0 transition
// ---------------------------------------------------------------------------
module sync_edge_det #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift chain plus one extra flop holding the previous synchronised level
    // so the edge pulses are always exactly one clock wide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q[0] <= din_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_pred_tx.sv
// ---------------------------------------------------------------------------
// spi_pred_tx
//
// SPI responder transmit path that returns branch predictions to the host.
// The core hands predictions over through a valid/ready handshake into a
// holding register. When the host drops chip-select the holding register is
// snapshotted into a shift register and a FRAME_BITS-long frame is driven
// MSB-first on miso, advanced by the host's sclk (mode 0: the host samples on
// the rising edge, so the next bit is presented after each falling edge).
//
// Ports:
//   clk        : system clock
//   rst        : asynchronous, active-high reset
//   pred_valid : core offers a new prediction
//   pred_ready : prediction accepted this cycle
//   pred_taken : predicted direction (1 = taken)
//   pred_sum   : signed perceptron output
//   cs         : host chip-select, active low (asynchronous)
//   sclk       : host serial clock (asynchronous)
//   miso       : serial data to the host
//   miso_oe    : pad output enable, high while selected
//   tx_done    : one-cycle pulse once a whole frame has been clocked out
//   overrun    : sticky flag, an unread prediction was overwritten
// ---------------------------------------------------------------------------
module spi_pred_tx
    import spi_pred_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pred_valid,
    output logic                 pred_ready,
    input  logic                 pred_taken,
    input  logic [SUM_WIDTH-1:0] pred_sum,
    input  logic                 cs,
    input  logic                 sclk,
    output logic                 miso,
    output logic                 miso_oe,
    output logic                 tx_done,
    output logic                 overrun
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);

    // ------------------------------------------------------------------
    // Host-side inputs brought into the clk domain
    // ------------------------------------------------------------------
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic sclk_level_unused;
    logic sclk_rise;
    logic sclk_fall;

    // Chip-select idles high, so its synchroniser resets high to avoid a
    // false cs_fall straight out of reset.
    sync_edge_det #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk     (clk),
        .rst     (rst),
        .din_i   (cs),
        .level_o (cs_level),
        .rise_o  (cs_rise),
        .fall_o  (cs_fall)
    );

    sync_edge_det #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sclk_sync (
        .clk     (clk),
        .rst     (rst),
        .din_i   (sclk),
        .level_o (sclk_level_unused),
        .rise_o  (sclk_rise),
        .fall_o  (sclk_fall)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [FRAME_BITS-1:0]  shift_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   hold_taken_q;
    logic [SUM_WIDTH-1:0]   hold_sum_q;
    logic                   fresh_q;
    logic                   overrun_q;
    logic                   miso_q;
    logic                   tx_done_q;

    logic [FRAME_BITS-1:0]  frame_snap;
    logic                   load;

    // The frame the host would see if chip-select fell right now.
    always_comb begin
        frame_snap                = '0;
        frame_snap[FRESH_BIT]     = fresh_q;
        frame_snap[OVR_BIT]       = overrun_q;
        frame_snap[TAKEN_BIT]     = hold_taken_q;
        frame_snap[SUM_WIDTH-1:0] = hold_sum_q;
    end

    assign shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
    assign cnt_d   = cnt_q + 1'b1;

    // Loads are refused while a frame is in flight so the snapshot can never
    // be torn. In IDLE a cs_fall in the same cycle wins over the load; the
    // held-off prediction is simply retried by the core. Ready is also held
    // low while rst is asserted so nothing is accepted during reset.
    assign pred_ready = ~rst & (((state_q == IDLE) & ~cs_fall) | (state_q == DONE));
    assign load       = pred_valid & pred_ready;

    // ------------------------------------------------------------------
    // Holding register and transmit FSM
    // ------------------------------------------------------------------
    // The holding register and its fresh/overrun flags share this block
    // with the FSM because completing a frame clears the flags that the
    // frame has just reported. Loads only happen in IDLE/DONE and the
    // clearing only in SHIFT, so the two never collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            hold_taken_q <= 1'b0;
            hold_sum_q   <= '0;
            fresh_q      <= 1'b0;
            overrun_q    <= 1'b0;
            miso_q       <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;

            if (load) begin
                hold_taken_q <= pred_taken;
                hold_sum_q   <= pred_sum;
                fresh_q      <= 1'b1;
                if (fresh_q) begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    miso_q <= 1'b0;
                    if (cs_fall) begin
                        shift_q <= frame_snap;
                        cnt_q   <= '0;
                        miso_q  <= frame_snap[FRAME_BITS-1];
                        state_q <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (cnt_q == CNT_LAST) begin
                        // Every bit has been sampled by the host; the status
                        // flags have now been reported. If chip-select is
                        // already going away, skip DONE so the rise is not lost.
                        tx_done_q <= 1'b1;
                        fresh_q   <= 1'b0;
                        overrun_q <= 1'b0;
                        miso_q    <= 1'b0;
                        state_q   <= cs_rise ? IDLE : DONE;
                    end else if (cs_rise) begin
                        // Aborted frame: flags untouched so it is resent.
                        miso_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (sclk_rise) begin
                        cnt_q <= cnt_d;
                    end else if (sclk_fall) begin
                        shift_q <= shift_d;
                        miso_q  <= shift_d[FRAME_BITS-1];
                    end
                end

                DONE: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    miso_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign miso    = miso_q;
    assign miso_oe = ~cs_level;
    assign tx_done = tx_done_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_spi_pred_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_pred_tx
//
// Self-checking bench for spi_pred_tx. The host side is modelled as a mode-0
// SPI master that samples miso just before each sclk rising edge. A small
// reference model tracks the prediction the host should see as plain fields
// (fresh, overrun, taken, sum) and produces the expected frame from them.
// ---------------------------------------------------------------------------
module tb_spi_pred_tx;

    localparam int SW   = 13;
    localparam int FB   = SW + 3;
    localparam int SYNC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          pred_valid;
    logic          pred_ready;
    logic          pred_taken;
    logic [SW-1:0] pred_sum;
    logic          cs;
    logic          sclk;
    logic          miso;
    logic          miso_oe;
    logic          tx_done;
    logic          overrun;

    int checks   = 0;
    int failures = 0;
    int txd_cnt  = 0;

    // Reference model of what the host should read next.
    logic          m_fresh = 1'b0;
    logic          m_ovr   = 1'b0;
    logic          m_taken = 1'b0;
    logic [SW-1:0] m_sum   = '0;

    spi_pred_tx #(
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pred_valid (pred_valid),
        .pred_ready (pred_ready),
        .pred_taken (pred_taken),
        .pred_sum   (pred_sum),
        .cs         (cs),
        .sclk       (sclk),
        .miso       (miso),
        .miso_oe    (miso_oe),
        .tx_done    (tx_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Count every clock cycle in which tx_done is high.
    always @(posedge clk) begin
        if (tx_done === 1'b1) txd_cnt++;
    end

    function automatic logic [FB-1:0] model_frame();
        return {m_fresh, m_ovr, m_taken, m_sum};
    endfunction

    task automatic model_load(input logic t, input logic [SW-1:0] s);
        if (m_fresh) m_ovr = 1'b1;
        m_fresh = 1'b1;
        m_taken = t;
        m_sum   = s;
    endtask

    task automatic model_report();
        m_fresh = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_reset();
        m_fresh = 1'b0;
        m_ovr   = 1'b0;
        m_taken = 1'b0;
        m_sum   = '0;
    endtask

    // Offer one prediction while idle; it must be accepted immediately.
    task automatic load_pred(input logic t, input logic [SW-1:0] s);
        @(negedge clk);
        pred_valid = 1'b1;
        pred_taken = t;
        pred_sum   = s;
        checks++;
        if (pred_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_ready: pred_ready=%b expected 1", pred_ready);
        end
        @(negedge clk);
        pred_valid = 1'b0;
        model_load(t, s);
    endtask

    // Host clocks n bits, sampling miso before each rising edge.
    task automatic shift_bits(input int n, output logic [FB-1:0] word);
        word = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            word = {word[FB-2:0], miso};
            sclk = 1'b1;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic read_frame(output logic [FB-1:0] word);
        @(negedge clk);
        cs = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        shift_bits(FB, word);
        repeat (3) @(negedge clk);
        cs = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
    endtask

    // Drop cs and raise pred_valid exactly in the cycle where the DUT sees
    // the synchronised cs_fall; ready must already be low there.
    task automatic start_frame_with_valid(input logic t, input logic [SW-1:0] s);
        @(negedge clk);
        cs = 1'b0;
        repeat (SYNC) @(posedge clk);
        #1;
        checks++;
        if (pred_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL csfall_ready: pred_ready=%b expected 0", pred_ready);
        end
        pred_valid = 1'b1;
        pred_taken = t;
        pred_sum   = s;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        cs         = 1'b1;
        sclk       = 1'b0;
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        pred_sum   = '0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (miso !== 1'b0)       begin failures++; $display("[TB] FAIL reset_miso: got %b expected 0", miso); end
        if (miso_oe !== 1'b0)    begin failures++; $display("[TB] FAIL reset_oe: got %b expected 0", miso_oe); end
        if (tx_done !== 1'b0)    begin failures++; $display("[TB] FAIL reset_txdone: got %b expected 0", tx_done); end
        if (overrun !== 1'b0)    begin failures++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        if (pred_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 0", pred_ready); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++;
        if (pred_ready !== 1'b1) begin failures++; $display("[TB] FAIL idle_ready: got %b expected 1", pred_ready); end
    endtask

    task automatic test_basic();
        logic [FB-1:0] w;
        logic [FB-1:0] exp;
        int            t0;
        load_pred(1'b1, 13'h00A5);
        exp = model_frame();
        t0  = txd_cnt;
        read_frame(w);
        model_report();
        checks += 2;
        if (w !== exp) begin failures++; $display("[TB] FAIL basic_frame1: got %h expected %h", w, exp); end
        if (txd_cnt - t0 != 1) begin failures++; $display("[TB] FAIL basic_txdone1: pulses=%0d expected 1", txd_cnt - t0); end
        exp = model_frame();
        t0  = txd_cnt;
        read_frame(w);
        checks += 2;
        if (w !== exp) begin failures++; $display("[TB] FAIL basic_frame2: got %h expected %h", w, exp); end
        if (txd_cnt - t0 != 1) begin failures++; $display("[TB] FAIL basic_txdone2: pulses=%0d expected 1", txd_cnt - t0); end
    endtask

    task automatic test_overrun();
        logic [FB-1:0] w;
        logic [FB-1:0] exp;
        load_pred(1'b1, 13'h0001);
        load_pred(1'b0, 13'h1FFF);
        checks++;
        if (overrun !== m_ovr) begin failures++; $display("[TB] FAIL ovr_set: got %b expected %b", overrun, m_ovr); end
        exp = model_frame();
        read_frame(w);
        model_report();
        checks += 2;
        if (w !== exp) begin failures++; $display("[TB] FAIL ovr_frame: got %h expected %h", w, exp); end
        if (overrun !== 1'b0) begin failures++; $display("[TB] FAIL ovr_clear: got %b expected 0", overrun); end
        exp = model_frame();
        read_frame(w);
        checks++;
        if (w !== exp) begin failures++; $display("[TB] FAIL ovr_after: got %h expected %h", w, exp); end
    endtask

    task automatic test_abort();
        logic [FB-1:0] w;
        logic [FB-1:0] exp;
        int            t0;
        load_pred(1'($urandom_range(0, 1)), SW'($urandom));
        exp = model_frame();
        t0  = txd_cnt;
        @(negedge clk);
        cs = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        shift_bits(5, w);
        cs = 1'b1;
        repeat (SYNC + 4) @(negedge clk);
        checks += 2;
        if (w[4:0] !== exp[FB-1:FB-5]) begin failures++; $display("[TB] FAIL abort_bits: got %b expected %b", w[4:0], exp[FB-1:FB-5]); end
        if (txd_cnt != t0) begin failures++; $display("[TB] FAIL abort_txdone: pulses=%0d expected 0", txd_cnt - t0); end
        read_frame(w);
        model_report();
        checks++;
        if (w !== exp) begin failures++; $display("[TB] FAIL abort_resend: got %h expected %h", w, exp); end
    endtask

    task automatic test_race();
        logic [FB-1:0] w;
        logic [FB-1:0] exp;
        logic [SW-1:0] other;
        load_pred(1'b0, 13'h0123);
        exp   = model_frame();
        other = 13'h1ABC;
        start_frame_with_valid(1'b1, other);
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        repeat (3) @(negedge clk);
        shift_bits(FB, w);
        repeat (3) @(negedge clk);
        cs = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        model_report();
        checks++;
        if (w !== exp) begin failures++; $display("[TB] FAIL race_frame: got %h expected %h", w, exp); end
        exp = model_frame();
        read_frame(w);
        checks++;
        if (w !== exp) begin failures++; $display("[TB] FAIL race_deferred: got %h expected %h", w, exp); end
    endtask

    task automatic test_hold_valid();
        logic [FB-1:0] w;
        logic [FB-1:0] exp;
        logic          nt;
        logic [SW-1:0] ns;
        logic          bad_ready;
        logic          bad_miso;
        logic          found;
        int            t0;
        load_pred(1'($urandom_range(0, 1)), SW'($urandom));
        exp       = model_frame();
        nt        = 1'($urandom_range(0, 1));
        ns        = SW'($urandom);
        t0        = txd_cnt;
        bad_ready = 1'b0;
        bad_miso  = 1'b0;
        found     = 1'b0;
        w         = '0;
        start_frame_with_valid(nt, ns);
        repeat (2) @(negedge clk);
        for (int i = 0; i < FB; i++) begin
            @(negedge clk);
            if (pred_ready !== 1'b0) bad_ready = 1'b1;
            w    = {w[FB-2:0], miso};
            sclk = 1'b1;
            if (i < FB - 1) begin
                repeat (4) begin @(negedge clk); if (pred_ready !== 1'b0) bad_ready = 1'b1; end
                sclk = 1'b0;
                repeat (3) begin @(negedge clk); if (pred_ready !== 1'b0) bad_ready = 1'b1; end
            end
        end
        for (int k = 0; k < 12 && !found; k++) begin
            @(negedge clk);
            if (tx_done === 1'b1) found = 1'b1;
        end
        checks += 4;
        if (bad_ready) begin failures++; $display("[TB] FAIL hold_ready_shift: pred_ready high during SHIFT, expected 0"); end
        if (w !== exp) begin failures++; $display("[TB] FAIL hold_frame: got %h expected %h", w, exp); end
        if (!found) begin failures++; $display("[TB] FAIL hold_txdone_timeout: tx_done=0 expected pulse within 12 cycles"); end
        if (pred_ready !== 1'b1) begin failures++; $display("[TB] FAIL hold_ready_done: got %b expected 1", pred_ready); end
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
        model_report();
        model_load(nt, ns);
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            sclk = 1'b0;
            repeat (4) begin @(negedge clk); if (miso !== 1'b0) bad_miso = 1'b1; end
            sclk = 1'b1;
            repeat (4) begin @(negedge clk); if (miso !== 1'b0) bad_miso = 1'b1; end
        end
        sclk = 1'b0;
        checks += 3;
        if (bad_miso) begin failures++; $display("[TB] FAIL done_miso: miso went high in DONE, expected 0"); end
        if (miso_oe !== 1'b1) begin failures++; $display("[TB] FAIL done_oe: got %b expected 1", miso_oe); end
        if (txd_cnt - t0 != 1) begin failures++; $display("[TB] FAIL hold_txdone_count: pulses=%0d expected 1", txd_cnt - t0); end
        repeat (3) @(negedge clk);
        cs = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        exp = model_frame();
        read_frame(w);
        model_report();
        checks++;
        if (w !== exp) begin failures++; $display("[TB] FAIL hold_loaded: got %h expected %h", w, exp); end
    endtask

    task automatic test_reset_mid();
        logic [FB-1:0] w;
        logic [FB-1:0] exp;
        load_pred(1'b1, SW'($urandom) | 13'h0100);
        exp = model_frame();
        @(negedge clk);
        cs = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        shift_bits(8, w);
        checks++;
        if (w[7:0] !== exp[FB-1:FB-8]) begin failures++; $display("[TB] FAIL rstmid_bits: got %h expected %h", w[7:0], exp[FB-1:FB-8]); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (miso !== 1'b0)       begin failures++; $display("[TB] FAIL rstmid_miso: got %b expected 0", miso); end
        if (miso_oe !== 1'b0)    begin failures++; $display("[TB] FAIL rstmid_oe: got %b expected 0", miso_oe); end
        if (overrun !== 1'b0)    begin failures++; $display("[TB] FAIL rstmid_overrun: got %b expected 0", overrun); end
        if (pred_ready !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_ready: got %b expected 0", pred_ready); end
        rst = 1'b0;
        model_reset();
        repeat (SYNC + 2) @(negedge clk);
        checks++;
        if (miso_oe !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_oe_cs_low: got %b expected 1", miso_oe); end
        cs = 1'b1;
        repeat (SYNC + 3) @(negedge clk);
        checks++;
        if (miso_oe !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_oe_cs_high: got %b expected 0", miso_oe); end
        exp = model_frame();
        read_frame(w);
        model_report();
        checks++;
        if (w !== exp) begin failures++; $display("[TB] FAIL rstmid_frame: got %h expected %h", w, exp); end
    endtask

    task automatic test_random();
        logic [FB-1:0] w;
        logic [FB-1:0] exp;
        int            nl;
        for (int it = 0; it < 6; it++) begin
            nl = $urandom_range(0, 3);
            for (int j = 0; j < nl; j++) begin
                load_pred(1'($urandom_range(0, 1)), SW'($urandom));
            end
            checks++;
            if (overrun !== m_ovr) begin failures++; $display("[TB] FAIL rand_ovr[%0d]: got %b expected %b", it, overrun, m_ovr); end
            exp = model_frame();
            read_frame(w);
            model_report();
            checks++;
            if (w !== exp) begin failures++; $display("[TB] FAIL rand_frame[%0d]: got %h expected %h", it, w, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_abort();
        test_race();
        test_hold_valid();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
